muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M/RV64M multiply/divide execute unit for the EX stage.
- Sits beside the single-cycle ALU. It is selected when ALUOp=2'b10 and Funct7=7'b0000001; Funct3 selects the operation.
- Uses a valid/ready handshake on both sides, so the pipeline stalls while the unit is busy.
- Generalises ALU-control decoding to multi-cycle M-extension ops, parametrised in XLEN.

Parameters:
- XLEN, 32, operand/result width; legal values are 32 and 64.
- CNT_W, $clog2(XLEN)+1, iteration counter width; derived localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept; high only in IDLE
- Funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  in  XLEN  rs1 value
- op_b  in  XLEN  rs2 value
- flush  in  1  kill in-flight op (branch mispredict / trap)
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- result  out  XLEN  rd value
- busy  out  1  high in CALC or DONE; drives hazard-unit stall

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0, out_valid=0, result=0, busy=0, in_ready=1.
  - Datapath registers are cleared to 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - An edge with in_valid&in_ready latches Funct3, the operand signs and the operand magnitudes.
  - Signedness per op: signed for MULH/DIV/REM; op_a signed, op_b unsigned for MULHSU; unsigned for MULHU/DIVU/REMU/MUL.
  - MUL takes the low word, so signedness is irrelevant for it.
  - Fast path goes to DONE in 1 edge:
    - divisor=0: quotient all-ones, remainder=op_a.
    - signed DIV/REM with op_a=MIN_INT and op_b=-1: quotient=MIN_INT, remainder=0.
  - Otherwise go to CALC with counter=0.
- CALC:
  - Performs one radix-2 iteration per edge and increments counter.
  - Multiply is shift-add into a 2*XLEN accumulator.
  - Divide is restoring, using a XLEN+1-bit partial remainder.
  - On the edge where counter reaches XLEN-1, apply sign correction:
    - product is negated if the operand signs differ;
    - quotient is negated if the signs differ;
    - remainder takes the dividend's sign.
  - On that edge, also select the low/high word or quotient/remainder, register it into result, and go to DONE.
- Latency: out_valid rises exactly XLEN+1 edges after the accept edge (33 for XLEN=32). The fast path gives 1 edge.
- DONE:
  - out_valid=1 and result is held stable until out_ready=1.
  - That edge clears out_valid and returns to IDLE.
  - No new accept is possible in the same cycle, since in_ready=0 outside IDLE. Minimum issue interval is therefore XLEN+2 cycles.
- flush:
  - Synchronous and highest priority. Any state goes to IDLE and out_valid=0.
  - result keeps its old value.
  - flush together with in_valid in IDLE: the request is not accepted.
- Asynchronous reset mid-CALC/DONE aborts immediately; no out_valid is produced afterwards.
- All arithmetic is two's complement modulo 2^XLEN, with no exceptions (per the RISC-V M spec).
- in_valid while busy is ignored; the requester must hold the request until in_ready.

Decomposition:
- muldiv_pkg holds:
  - state_e enum {IDLE, CALC, DONE};
  - the Funct3 op localparams MUL…REMU;
  - FUNCT7_MULDIV=7'b0000001;
  - a function is_signed_a/is_signed_b(funct3).
- One sub-module, muldiv_core: the per-iteration shift-add/restoring datapath step (combinational, XLEN-parametrised).
- The FSM, counter and sign correction stay in muldiv_unit.

Test Plan:
- MUL 7 × 0xFFFFFFFD (XLEN=32) → result 0xFFFFFFEB; out_valid exactly 33 edges after accept; busy high throughout.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- Divide by zero:
  - DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, each with 1-edge latency.
  - Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, each with 1-edge latency.
- flush asserted 10 cycles after accept → no out_valid ever; in_ready=1 next cycle; a following MUL 3×4 → 12 at 33 edges.
- Backpressure and reset:
  - out_ready held low 5 cycles in DONE → result/out_valid stable, in_valid ignored.
  - rst_n pulsed low mid-CALC → all outputs at reset values immediately, in_ready=1.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M/RV64M multiply/divide unit.
//   state_e        : FSM states of muldiv_unit
//   MUL..REMU      : Funct3 operation encodings
//   FUNCT7_MULDIV  : Funct7 value selecting the M extension
//   is_signed_a/b  : operand signedness per operation
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // MUL only keeps the low word, which is sign-agnostic, so it is treated as unsigned.
  function automatic logic is_signed_a(input logic [2:0] funct3);
    return (funct3 == MULH) || (funct3 == MULHSU) || (funct3 == DIV) || (funct3 == REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] funct3);
    return (funct3 == MULH) || (funct3 == DIV) || (funct3 == REM);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// One radix-2 iteration of the unsigned multiply/divide datapath (combinational).
//   is_div  : 1 = restoring divide step, 0 = shift-add multiply step
//   hi      : multiply: upper accumulator half; divide: partial remainder
//   lo      : multiply: lower accumulator / remaining multiplier bits;
//             divide: dividend bits shifting out, quotient bits shifting in
//   m       : multiplicand (multiply) or divisor (divide), magnitudes
//   hi_next : next hi
//   lo_next : next lo
module muldiv_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] m,
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    // Multiply: add multiplicand when the current multiplier bit is set, then shift the
    // whole {carry, hi, lo} right by one.
    sum     = {1'b0, hi} + {1'b0, m & {XLEN{lo[0]}}};
    // Divide: bring the next dividend bit into the remainder and trial-subtract.
    shifted = {hi, lo[XLEN-1]};
    diff    = shifted - {1'b0, m};

    if (is_div) begin
      // The remainder stays below the divisor, so its top bit is always zero and the
      // low XLEN bits of diff/shifted are exact.
      if (!diff[XLEN]) begin
        hi_next = diff[XLEN-1:0];
        lo_next = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_next = shifted[XLEN-1:0];
        lo_next = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_next = sum[XLEN:1];
      lo_next = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative M-extension execute unit: one radix-2 step per cycle on operand magnitudes,
// sign correction on the final step, valid/ready handshake on both sides.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : request handshake (in_ready high only in IDLE)
//   Funct3, op_a, op_b   : operation and rs1/rs2 values
//   flush                : kill any in-flight operation, highest priority
//   out_valid / out_ready: result handshake
//   result               : rd value, held until taken
//   busy                 : high while an operation occupies the unit
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic [XLEN-1:0]   m_q, m_d;       // multiplicand or divisor magnitude
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [XLEN-1:0]   core_hi, core_lo;

  logic              in_sa, in_sb;
  logic [XLEN-1:0]   mag_a, mag_b;

  logic [2*XLEN-1:0] prod_raw, prod;
  logic [XLEN-1:0]   quot, rem, fin;

  muldiv_core #(
    .XLEN (XLEN)
  ) u_core (
    .is_div  (f3_q[2]),
    .hi      (hi_q),
    .lo      (lo_q),
    .m       (m_q),
    .hi_next (core_hi),
    .lo_next (core_lo)
  );

  // Operand magnitudes at accept time; |MIN_INT| is representable as unsigned.
  always_comb begin
    in_sa = is_signed_a(Funct3) & op_a[XLEN-1];
    in_sb = is_signed_b(Funct3) & op_b[XLEN-1];
    mag_a = in_sa ? -op_a : op_a;
    mag_b = in_sb ? -op_b : op_b;
  end

  // Sign correction and word selection applied to the last iteration's outputs.
  always_comb begin
    prod_raw = {core_hi, core_lo};
    prod     = (sign_a_q ^ sign_b_q) ? -prod_raw : prod_raw;
    quot     = (sign_a_q ^ sign_b_q) ? -core_lo : core_lo;
    rem      = sign_a_q ? -core_hi : core_hi;
    case (f3_q)
      MUL:                 fin = prod[XLEN-1:0];
      MULH, MULHSU, MULHU: fin = prod[2*XLEN-1:XLEN];
      DIV, DIVU:           fin = quot;
      default:             fin = rem;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    m_d      = m_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;

    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            f3_d     = Funct3;
            sign_a_d = in_sa;
            sign_b_d = in_sb;
            cnt_d    = '0;
            hi_d     = '0;
            if (Funct3[2]) begin
              m_d  = mag_b;
              lo_d = mag_a;
            end else begin
              m_d  = mag_a;
              lo_d = mag_b;
            end

            if (Funct3[2] && (op_b == '0)) begin
              result_d = Funct3[1] ? op_a : '1;
              state_d  = DONE;
            end else if (((Funct3 == DIV) || (Funct3 == REM)) &&
                         (op_a == MIN_INT) && (op_b == '1)) begin
              result_d = Funct3[1] ? '0 : MIN_INT;
              state_d  = DONE;
            end else begin
              state_d = CALC;
            end
          end
        end

        CALC: begin
          hi_d  = core_hi;
          lo_d  = core_lo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            result_d = fin;
            state_d  = DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      m_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      m_q      <= m_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at XLEN=32.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        flush     = 1'b0;
  logic        out_ready = 1'b0;
  logic [2:0]  Funct3    = 3'b000;
  logic [31:0] op_a      = 32'h0;
  logic [31:0] op_b      = 32'h0;
  logic        in_ready;
  logic        out_valid;
  logic        busy;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(
    .XLEN (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Funct3    (Funct3),
    .op_a      (op_a),
    .op_b      (op_b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, measure edges from accept to out_valid, optionally hold off out_ready
  // for 'hold' cycles while presenting a competing request, then consume the result.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input int hold);
    int   lat;
    logic busy_ok;
    logic stable_ok;
    @(negedge clk);
    check({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
    Funct3   = f3;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat      = 1;
    busy_ok  = 1'b1;
    while (out_valid !== 1'b1 && lat < 100) begin
      busy_ok &= (busy === 1'b1);
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, result, exp);
    check({tag, "_busy"}, {31'b0, busy_ok & (busy === 1'b1)}, 32'd1);
    stable_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      Funct3   = MUL;
      op_a     = 32'(i + 1);
      op_b     = 32'h11;
      @(posedge clk);
      #1;
      stable_ok &= (out_valid === 1'b1) && (result === exp) && (in_ready === 1'b0);
    end
    check({tag, "_hold"}, {31'b0, stable_ok}, 32'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_done"}, {29'b0, out_valid, in_ready, busy}, 32'b010);
  endtask

  initial begin
    logic seen;

    // Reset values
    #2;
    check("rst_rdy", {31'b0, in_ready}, 32'd1);
    check("rst_ov", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_res", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Multiply
    run_op("mul", MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);
    run_op("mulh", MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0);
    run_op("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
    run_op("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0);

    // Divide
    run_op("div", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
    run_op("rem", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
    run_op("divu", DIVU, 32'd100, 32'd7, 32'd14, 33, 0);
    run_op("remu_bp", REMU, 32'd100, 32'd7, 32'd2, 33, 5);

    // Flush 10 cycles after accept; result keeps the REMU value
    @(negedge clk);
    Funct3   = MUL;
    op_a     = 32'd5;
    op_b     = 32'd6;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_ov", {31'b0, out_valid}, 32'd0);
    check("flush_rdy", {31'b0, in_ready}, 32'd1);
    check("flush_res", result, 32'd2);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen |= out_valid;
    end
    check("flush_quiet", {31'b0, seen}, 32'd0);

    // Flush together with a request in IDLE: not accepted
    @(negedge clk);
    Funct3   = MUL;
    op_a     = 32'd9;
    op_b     = 32'd9;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush_idle", {30'b0, in_ready, busy}, 32'b10);

    run_op("mul34", MUL, 32'd3, 32'd4, 32'd12, 33, 0);

    // Fast paths
    run_op("div0", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_op("rem0", REM, 32'd5, 32'd0, 32'd5, 1, 0);
    run_op("remu0", REMU, 32'd9, 32'd0, 32'd9, 1, 0);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    Funct3   = MULHU;
    op_a     = 32'h1234_5678;
    op_b     = 32'h9ABC_DEF0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out", {29'b0, out_valid, in_ready, busy}, 32'b010);
    check("arst_res", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen |= out_valid;
    end
    check("arst_quiet", {31'b0, seen}, 32'd0);

    run_op("mul_neg", MUL, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'd15, 33, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
